// File: rtl/gambling_pkg.sv
// Shared definitions for the Gambling_Tec data-memory subsystem.
//   - req_e     : requester identifiers used for grants and read-return tags
//   - DATA_W    : data-memory word width
//   - *_ADDR    : word addresses used by the keyboard, counter and video paths
//   - SYM_*     : word addresses of the three symbol bitmaps fetched by video
//   - rr_other  : returns the round-robin peer of a KBD/VGA requester
package gambling_pkg;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_KBD = 2'd1,
        REQ_VGA = 2'd2
    } req_e;

    localparam int DATA_W   = 32;

    localparam int KBD_ADDR = 10;
    localparam int CNT_ADDR = 16;
    localparam int VGA_ADDR = 32;
    localparam int SYM_A    = 32'h1030;
    localparam int SYM_B    = 32'h1040;
    localparam int SYM_C    = 32'h1050;

    // After serving one of the two round-robin requesters, the pointer
    // moves to the other one.
    function automatic req_e rr_other(input req_e granted);
        return (granted == REQ_KBD) ? REQ_VGA : REQ_KBD;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating wait counter for one low-priority requester.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   i_req     : requester is asking for the memory port
//   i_gnt     : requester was granted this cycle
//   o_starved : counter has reached MAX_WAIT; the requester must win next
module starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starved
);

    localparam int            CW  = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;

    // Counts consecutive cycles of an outstanding, ungranted request.
    // Dropping the request or being served restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != SAT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_starved = (r_cnt == SAT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-RAM port among CPU, KBD and VGA.
//   Requester ports (x = cpu, kbd, vga):
//     x_req/x_we/x_addr/x_wdata : access request, held until granted
//     x_gnt                     : request accepted this cycle
//     x_rvalid                  : read data for x is on rdata this cycle
//   rdata     : shared read-return bus, 0 when no read returns
//   cpu_stall : CPU is requesting but not granted
//   mem_*     : synchronous RAM port; mem_rdata is valid the cycle after mem_en
//
// Handshake: a requester raises x_req with its command and keeps it stable
// until it sees x_gnt in the same cycle; that cycle (x_req & x_gnt) is the
// transfer. Read data follows exactly one cycle later with x_rvalid.
//
// CPU has fixed priority except when a KBD/VGA request has waited MAX_WAIT
// cycles; KBD and VGA share the remaining slots by round robin.
module dmem_arbiter
    import gambling_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 8192,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              kbd_req,
    input  logic              kbd_we,
    input  logic [ADDR_W-1:0] kbd_addr,
    input  logic [DATA_W-1:0] kbd_wdata,
    output logic              kbd_gnt,
    output logic              kbd_rvalid,

    input  logic              vga_req,
    input  logic              vga_we,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic              vga_gnt,
    output logic              vga_rvalid,

    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    req_e              r_rr;        // next KBD/VGA winner when both contend
    req_e              r_owner;     // requester of the read in flight
    logic              r_rd_pend;   // a read was accepted last cycle
    logic              r_oor;       // that read was out of range

    logic              w_kbd_starved;
    logic              w_vga_starved;
    logic              w_sk;
    logic              w_sv;
    logic              w_any;
    req_e              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_kbd_wait (
        .clk       (clk),
        .rst       (rst),
        .i_req     (kbd_req),
        .i_gnt     (kbd_gnt),
        .o_starved (w_kbd_starved)
    );

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_vga_wait (
        .clk       (clk),
        .rst       (rst),
        .i_req     (vga_req),
        .i_gnt     (vga_gnt),
        .o_starved (w_vga_starved)
    );

    // Winner selection. Everything is gated by rst so that no grant, and
    // hence no RAM write, can escape while reset is asserted.
    always_comb begin
        w_any = 1'b0;
        w_sel = REQ_CPU;
        w_sk  = kbd_req & w_kbd_starved;
        w_sv  = vga_req & w_vga_starved;
        if (!rst) begin
            w_any = 1'b0;
        end else if (w_sk && w_sv) begin
            w_any = 1'b1;
            w_sel = r_rr;
        end else if (w_sk) begin
            w_any = 1'b1;
            w_sel = REQ_KBD;
        end else if (w_sv) begin
            w_any = 1'b1;
            w_sel = REQ_VGA;
        end else if (cpu_req) begin
            w_any = 1'b1;
            w_sel = REQ_CPU;
        end else if (kbd_req && vga_req) begin
            w_any = 1'b1;
            w_sel = r_rr;
        end else if (kbd_req) begin
            w_any = 1'b1;
            w_sel = REQ_KBD;
        end else if (vga_req) begin
            w_any = 1'b1;
            w_sel = REQ_VGA;
        end
    end

    assign cpu_gnt   = w_any && (w_sel == REQ_CPU);
    assign kbd_gnt   = w_any && (w_sel == REQ_KBD);
    assign vga_gnt   = w_any && (w_sel == REQ_VGA);
    assign cpu_stall = rst & cpu_req & ~cpu_gnt;

    // Command of the granted requester.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (w_sel)
            REQ_CPU: begin
                w_we    = cpu_we;
                w_addr  = cpu_addr;
                w_wdata = cpu_wdata;
            end
            REQ_KBD: begin
                w_we    = kbd_we;
                w_addr  = kbd_addr;
                w_wdata = kbd_wdata;
            end
            REQ_VGA: begin
                w_we    = vga_we;
                w_addr  = vga_addr;
                w_wdata = vga_wdata;
            end
            default: begin
                w_we    = 1'b0;
                w_addr  = '0;
                w_wdata = '0;
            end
        endcase
    end

    assign w_in_range = ({1'b0, w_addr} < DEPTH_CMP);

    // Out-of-range accesses never reach the RAM; the port rests at zero.
    assign mem_en    = w_any & w_in_range;
    assign mem_we    = mem_en & w_we;
    assign mem_addr  = mem_en ? w_addr  : '0;
    assign mem_wdata = mem_en ? w_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr      <= REQ_KBD;
            r_owner   <= REQ_CPU;
            r_rd_pend <= 1'b0;
            r_oor     <= 1'b0;
        end else begin
            if (w_any && (w_sel != REQ_CPU)) begin
                r_rr <= rr_other(w_sel);
            end
            r_rd_pend <= w_any & ~w_we;
            r_owner   <= w_sel;
            r_oor     <= ~w_in_range;
        end
    end

    assign cpu_rvalid = r_rd_pend && (r_owner == REQ_CPU);
    assign kbd_rvalid = r_rd_pend && (r_owner == REQ_KBD);
    assign vga_rvalid = r_rd_pend && (r_owner == REQ_VGA);
    assign rdata      = (r_rd_pend && !r_oor) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import gambling_pkg::*;

    localparam int AW    = 14;
    localparam int DEPTH = 8192;
    localparam int MW    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we, kbd_req, kbd_we, vga_req, vga_we;
    logic [AW-1:0] cpu_addr, kbd_addr, vga_addr;
    logic [31:0]   cpu_wdata, kbd_wdata, vga_wdata;
    logic          cpu_gnt, kbd_gnt, vga_gnt;
    logic          cpu_rvalid, kbd_rvalid, vga_rvalid;
    logic [31:0]   rdata;
    logic          cpu_stall;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .kbd_req(kbd_req), .kbd_we(kbd_we), .kbd_addr(kbd_addr), .kbd_wdata(kbd_wdata),
        .kbd_gnt(kbd_gnt), .kbd_rvalid(kbd_rvalid),
        .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
        .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
        .rdata(rdata), .cpu_stall(cpu_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous RAM attached to the arbiter's port.
    logic [31:0] ram    [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[12:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[12:0]];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_err    = 0;

    int          m_wk, m_wv, m_rr;     // wait counts, rr: 1 = KBD, 2 = VGA
    bit          p_valid;              // expected read return next cycle
    int          p_owner;
    logic [31:0] p_data;
    logic [31:0] exp_q[$];             // expected VGA symbol words

    // Observed values of the last cycle, for directed checks.
    logic [2:0]  o_gnt, o_rv;
    logic [31:0] o_rdata;
    logic        o_stall, o_mem_en, o_mem_we;
    int          m_last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wk = 0; m_wv = 0; m_rr = 1; p_valid = 0; p_owner = -1; p_data = '0;
    endtask

    // Expected winner: -1 none, 0 CPU, 1 KBD, 2 VGA.
    function automatic int winner();
        bit sk, sv;
        sk = kbd_req && (m_wk == MW);
        sv = vga_req && (m_wv == MW);
        if (sk && sv) return m_rr;
        if (sk) return 1;
        if (sv) return 2;
        if (cpu_req) return 0;
        if (kbd_req && vga_req) return m_rr;
        if (kbd_req) return 1;
        if (vga_req) return 2;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return AW'(SYM_A);
            1: return AW'(CNT_ADDR);
            2: return AW'($urandom_range(DEPTH, (1 << AW) - 1));
            default: return AW'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    // One clock cycle with inputs already applied: check every output
    // against the model mid-cycle, then advance the model.
    task automatic cyc();
        int w; logic we; logic [AW-1:0] a; logic [31:0] d; bit inr;
        @(negedge clk);
        w = winner();
        we = 1'b0; a = '0; d = '0;
        case (w)
            0: begin we = cpu_we; a = cpu_addr; d = cpu_wdata; end
            1: begin we = kbd_we; a = kbd_addr; d = kbd_wdata; end
            2: begin we = vga_we; a = vga_addr; d = vga_wdata; end
            default: ;
        endcase
        inr = (w >= 0) && (a < AW'(DEPTH));
        chk("cpu_gnt",    32'(cpu_gnt),    32'(w == 0));
        chk("kbd_gnt",    32'(kbd_gnt),    32'(w == 1));
        chk("vga_gnt",    32'(vga_gnt),    32'(w == 2));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && w != 0));
        chk("mem_en",     32'(mem_en),     32'(inr));
        chk("mem_we",     32'(mem_we),     32'(inr && we));
        chk("mem_addr",   32'(mem_addr),   inr ? 32'(a) : 32'd0);
        chk("mem_wdata",  mem_wdata,       inr ? d : 32'd0);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_valid && p_owner == 0));
        chk("kbd_rvalid", 32'(kbd_rvalid), 32'(p_valid && p_owner == 1));
        chk("vga_rvalid", 32'(vga_rvalid), 32'(p_valid && p_owner == 2));
        chk("rdata",      rdata,           p_valid ? p_data : 32'd0);
        o_gnt = {vga_gnt, kbd_gnt, cpu_gnt};
        o_rv  = {vga_rvalid, kbd_rvalid, cpu_rvalid};
        o_rdata = rdata; o_stall = cpu_stall; o_mem_en = mem_en; o_mem_we = mem_we;
        m_last_w = w;
        p_valid = (w >= 0) && !we;
        p_owner = w;
        p_data  = inr ? shadow[a[12:0]] : 32'd0;
        if (w >= 0 && we && inr) shadow[a[12:0]] = d;
        m_wk = (kbd_req && w != 1) ? ((m_wk < MW) ? m_wk + 1 : MW) : 0;
        m_wv = (vga_req && w != 2) ? ((m_wv < MW) ? m_wv + 1 : MW) : 0;
        if (w == 1) m_rr = 2;
        else if (w == 2) m_rr = 1;
        @(posedge clk); #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_gnt"},    32'({vga_gnt, kbd_gnt, cpu_gnt}),          32'd0);
        chk({tag, "_rvalid"}, 32'({vga_rvalid, kbd_rvalid, cpu_rvalid}), 32'd0);
        chk({tag, "_rdata"},  rdata,                                      32'd0);
        chk({tag, "_stall"},  32'(cpu_stall),                             32'd0);
        chk({tag, "_mem_en"}, 32'({mem_en, mem_we}),                      32'd0);
        chk({tag, "_maddr"},  32'(mem_addr),                              32'd0);
        chk({tag, "_mwdata"}, mem_wdata,                                  32'd0);
    endtask

    task automatic idle_all();
        cpu_req = 0; kbd_req = 0; vga_req = 0;
        cpu_we = 0; kbd_we = 0; vga_we = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 0; #1;
        rst_chk("reset_a");
        @(posedge clk); #1;
        rst_chk("reset_b");
        @(negedge clk); rst = 1; model_reset();
        @(posedge clk); #1;
    endtask

    // Failsafe so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int g1, g2, kc, vc;
        logic [31:0] syms [3];
        logic [31:0] e;
        rst = 1;
        idle_all();
        cpu_addr = '0; kbd_addr = '0; vga_addr = '0;
        cpu_wdata = '0; kbd_wdata = '0; vga_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; shadow[i] = '0; end
        syms[0] = 32'hA5A5_1030; syms[1] = 32'h5A5A_1040; syms[2] = 32'hC3C3_1050;
        ram[CNT_ADDR] = 32'd5;   shadow[CNT_ADDR] = 32'd5;
        ram[SYM_A] = syms[0];    shadow[SYM_A] = syms[0];
        ram[SYM_B] = syms[1];    shadow[SYM_B] = syms[1];
        ram[SYM_C] = syms[2];    shadow[SYM_C] = syms[2];
        model_reset();
        #2 rst = 0;
        @(negedge clk); rst_chk("por");
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // CPU alone reads word 16.
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(CNT_ADDR);
        cyc();
        chk("cpu_alone_gnt", 32'(o_gnt), 32'b001);
        chk("cpu_alone_stall", 32'(o_stall), 32'd0);
        cpu_req = 0;
        cyc();
        chk("cpu_alone_rv", 32'(o_rv), 32'b001);
        chk("cpu_alone_rdata", o_rdata, 32'd5);

        // KBD writes SPACE to word 10 against a continuously busy CPU.
        kbd_req = 1; kbd_we = 1; kbd_addr = AW'(KBD_ADDR); kbd_wdata = 32'h29;
        cpu_req = 1; cpu_we = 0;
        g1 = 0;
        for (int i = 1; i <= MW + 4 && g1 == 0; i++) begin
            cpu_addr = AW'($urandom_range(0, DEPTH - 1));
            cyc();
            if (o_gnt[1]) begin
                g1 = i; kbd_req = 0;
                chk("kbd_cont_stall", 32'(o_stall), 32'd1);
            end
        end
        chk("kbd_cont_cycle", 32'(g1), 32'(MW + 1));
        cpu_req = 0;
        cyc();
        chk("kbd_ram10", ram[KBD_ADDR], 32'h29);

        // Both KBD and VGA starved behind the CPU.
        cpu_req = 1; kbd_req = 1; kbd_we = 0; kbd_addr = AW'(CNT_ADDR);
        vga_req = 1; vga_we = 0; vga_addr = AW'(VGA_ADDR);
        kc = 0; vc = 0;
        for (int i = 1; i <= MW + 4 && (kc == 0 || vc == 0); i++) begin
            cpu_addr = AW'($urandom_range(0, DEPTH - 1));
            cyc();
            if (o_gnt[1]) begin kc = i; kbd_req = 0; end
            if (o_gnt[2]) begin vc = i; vga_req = 0; end
        end
        chk("starve_first",  32'((kc < vc) ? kc : vc), 32'(MW + 1));
        chk("starve_second", 32'((kc < vc) ? vc : kc), 32'(MW + 2));
        idle_all();
        cyc();

        // Fairness from reset: KBD, VGA, KBD, ...
        do_reset();
        kbd_req = 1; vga_req = 1; kbd_we = 0; vga_we = 0;
        for (int i = 0; i < 6; i++) begin
            kbd_addr = AW'($urandom_range(0, DEPTH - 1));
            vga_addr = AW'($urandom_range(0, DEPTH - 1));
            cyc();
            chk("rr_order", 32'(o_gnt), (i % 2 == 0) ? 32'b010 : 32'b100);
        end
        idle_all();
        cyc();

        // VGA symbol fetches back-to-back.
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                vga_req = 1; vga_we = 0;
                vga_addr = (i == 0) ? AW'(SYM_A) : (i == 1) ? AW'(SYM_B) : AW'(SYM_C);
                exp_q.push_back(syms[i]);
            end else begin
                vga_req = 0;
            end
            cyc();
            if (i > 0) begin
                e = exp_q.pop_front();
                chk("vga_sym_rv", 32'(o_rv), 32'b100);
                chk("vga_sym_data", o_rdata, e);
            end
        end

        // Out-of-range write and read at DEPTH.
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'(DEPTH); cpu_wdata = 32'hDEAD_BEEF;
        cyc();
        chk("oor_wr_gnt", 32'(o_gnt), 32'b001);
        chk("oor_wr_we",  32'({o_mem_en, o_mem_we}), 32'd0);
        cpu_we = 0;
        cyc();
        chk("oor_rd_we", 32'(o_mem_we), 32'd0);
        cpu_req = 0;
        cyc();
        chk("oor_rd_rv",    32'(o_rv), 32'b001);
        chk("oor_rd_rdata", o_rdata,   32'd0);
        chk("oor_no_alias", ram[0],    32'd0);

        // Random traffic with held requests; CPU kept busy to force starvation.
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req && $urandom_range(0, 7) != 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (!kbd_req && $urandom_range(0, 3) == 0) begin
                kbd_req = 1; kbd_we = 1'($urandom_range(0, 1));
                kbd_addr = rand_addr(); kbd_wdata = $urandom;
            end
            if (!vga_req && $urandom_range(0, 3) == 0) begin
                vga_req = 1; vga_we = 1'($urandom_range(0, 1));
                vga_addr = rand_addr(); vga_wdata = $urandom;
            end
            cyc();
            if (m_last_w == 0) cpu_req = 0;
            if (m_last_w == 1) kbd_req = 0;
            if (m_last_w == 2) vga_req = 0;
        end
        idle_all();
        cyc();

        // Reset asserted during a VGA read grant cycle.
        vga_req = 1; vga_we = 0; vga_addr = AW'(SYM_B);
        @(negedge clk);
        chk("rst_mid_pre_gnt", 32'(vga_gnt), 32'd1);
        #1 rst = 0;
        #1 rst_chk("rst_mid_a");
        @(posedge clk); #1;
        rst_chk("rst_mid_b");
        @(negedge clk);
        rst_chk("rst_mid_c");
        vga_req = 0; rst = 1; model_reset();
        #1 chk("rst_rel_rv", 32'(vga_rvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_post_rv", 32'(o_rv), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
